// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared widths and types for the writeback queue.
//   WB_ADDR_W : writeback destination width (6 bits; bit 5 marks non-RF targets)
//   WB_DATA_W : writeback data width
//   RF_ADDR_W : register-file read address width used for hazard lookup
//   wb_req_t  : one queued writeback {waddr, data}
//   wb_addr_match() : compares a 6-bit writeback address with a 5-bit read
//                     address; entries with bit 5 set never match a read port.
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int WB_ADDR_W = 6;
  localparam int WB_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] waddr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic wb_addr_match(input logic [WB_ADDR_W-1:0] waddr,
                                         input logic [RF_ADDR_W-1:0] raddr);
    return waddr == {1'b0, raddr};
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// In-order storage for pending writebacks: up to two pushes and one pop per
// cycle. Pointers wrap modulo DEPTH (power of two). The raw entry array and
// the read pointer are exported so the parent can search pending entries.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   push_cnt_i    : number of entries written this cycle (0..2)
//   push0_i       : entry written first (older)
//   push1_i       : entry written second (younger), used when push_cnt_i == 2
//   pop_i         : remove the head entry this cycle
//   head_o        : entry at the read pointer
//   count_o       : registered occupancy (0..DEPTH)
//   rd_ptr_o      : read pointer (index of the oldest entry)
//   entries_o     : storage array, valid where offset from rd_ptr_o < count_o
//
// The parent guarantees push_cnt_i never exceeds DEPTH - count_o and that
// pop_i is only asserted with count_o > 0.
// -----------------------------------------------------------------------------
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       push_cnt_i,
  input  wb_req_t          push0_i,
  input  wb_req_t          push1_i,
  input  logic             pop_i,
  output wb_req_t          head_o,
  output logic [CNT_W-1:0] count_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output wb_req_t          entries_o [DEPTH]
);

  wb_req_t          mem_q [DEPTH];
  wb_req_t          mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_p1;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    wr_ptr_p1 = wr_ptr_q + PTR_W'(1);

    if (push_cnt_i != 2'd0) begin
      mem_d[wr_ptr_q] = push0_i;
    end
    if (push_cnt_i == 2'd2) begin
      mem_d[wr_ptr_p1] = push1_i;
    end
    // Natural overflow of the pointer width implements the modulo-DEPTH wrap.
    wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt_i);

    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    count_d = count_q + CNT_W'(push_cnt_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign entries_o = mem_q;

endmodule

// File: rtl/wb_queue.sv
// -----------------------------------------------------------------------------
// wb_queue
// Writeback queue between two result sources (load path = older, ALU path =
// younger) and a single register-file write port. Accepted requests are kept
// in order; one entry is written per cycle through registered outputs.
// Pending writes are reported as hazards against two read addresses and,
// optionally, forwarded.
//
// Configuration macro: WB_FWD_EN
//   defined   : fwdK_valid = hazardK, fwdK_data = youngest matching pending data
//   undefined : fwdK_valid / fwdK_data tied to 0, no forwarding mux
//
// Ports
//   clk, rst_n                      : clock, asynchronous active-low reset
//   mem_valid/mem_waddr/mem_data    : load-path writeback request (older)
//   alu_valid/alu_waddr/alu_data    : ALU-path writeback request (younger)
//   mem_ready, alu_ready            : request accepted when valid && ready
//   we, waddr, din                  : registered register-file write port
//   raddr0, raddr1                  : read addresses for hazard lookup
//   hazard0, hazard1                : a pending write targets raddr0/raddr1
//   fwd0_valid/fwd0_data,
//   fwd1_valid/fwd1_data            : forwarded pending values
//
// Handshake: a request transfers on a rising edge where valid && ready are
// both high; ready depends only on registered occupancy and mem_valid, never
// on the request payload, and a dropped valid simply means no transfer.
// -----------------------------------------------------------------------------
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_valid,
  input  logic [WB_ADDR_W-1:0] mem_waddr,
  input  logic [WB_DATA_W-1:0] mem_data,
  input  logic                 alu_valid,
  input  logic [WB_ADDR_W-1:0] alu_waddr,
  input  logic [WB_DATA_W-1:0] alu_data,
  output logic                 mem_ready,
  output logic                 alu_ready,
  output logic                 we,
  output logic [WB_ADDR_W-1:0] waddr,
  output logic [WB_DATA_W-1:0] din,
  input  logic [RF_ADDR_W-1:0] raddr0,
  input  logic [RF_ADDR_W-1:0] raddr1,
  output logic                 hazard0,
  output logic                 hazard1,
  output logic                 fwd0_valid,
  output logic [WB_DATA_W-1:0] fwd0_data,
  output logic                 fwd1_valid,
  output logic [WB_DATA_W-1:0] fwd1_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  wb_req_t          head;
  wb_req_t          entries [DEPTH];
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic [1:0]       push_cnt;
  wb_req_t          push0;
  wb_req_t          push1;
  logic             pop;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_cnt_i (push_cnt),
    .push0_i    (push0),
    .push1_i    (push1),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count),
    .rd_ptr_o   (rd_ptr),
    .entries_o  (entries)
  );

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] free;
  logic             mem_acc;
  logic             alu_acc;
  logic [1:0]       n_acc;
  logic             queue_empty;
  logic             bypass;
  wb_req_t          mem_req;
  wb_req_t          alu_req;
  wb_req_t          first_req;

  // The pop happening this cycle is deliberately not credited to free, so
  // ready never depends on the drain and count can never exceed DEPTH.
  assign free      = CNT_W'(DEPTH) - count;
  assign mem_ready = (free >= CNT_W'(1));
  assign alu_ready = mem_valid ? (free >= CNT_W'(2)) : (free >= CNT_W'(1));

  assign mem_acc = mem_valid && mem_ready;
  assign alu_acc = alu_valid && alu_ready;
  assign n_acc   = {1'b0, mem_acc} + {1'b0, alu_acc};

  assign mem_req   = '{waddr: mem_waddr, data: mem_data};
  assign alu_req   = '{waddr: alu_waddr, data: alu_data};
  // mem is the older instruction, so it always goes first.
  assign first_req = mem_acc ? mem_req : alu_req;

  assign queue_empty = (count == '0);
  // An empty queue hands the oldest accepted request straight to the output
  // register, giving one-cycle latency; anything younger is stored.
  assign bypass = queue_empty && (n_acc != 2'd0);

  always_comb begin
    push_cnt = n_acc;
    push0    = first_req;
    push1    = alu_req;
    pop      = !queue_empty;
    if (bypass) begin
      push_cnt = n_acc - 2'd1;
      push0    = alu_req;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic                 we_q, we_d;
  logic [WB_ADDR_W-1:0] waddr_q, waddr_d;
  logic [WB_DATA_W-1:0] din_q, din_d;

  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    din_d   = din_q;
    if (pop) begin
      we_d    = 1'b1;
      waddr_d = head.waddr;
      din_d   = head.data;
    end else if (bypass) begin
      we_d    = 1'b1;
      waddr_d = first_req.waddr;
      din_d   = first_req.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      din_q   <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      din_q   <= din_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign din   = din_q;

  // ---------------------------------------------------------------------------
  // Hazard lookup (pending entries + output register; incoming requests are
  // intentionally excluded). Reset clears count and we_q asynchronously, so
  // hazards drop to 0 as soon as rst_n falls.
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] idx;

  always_comb begin
    hazard0 = we_q && wb_addr_match(waddr_q, raddr0);
    hazard1 = we_q && wb_addr_match(waddr_q, raddr1);
    idx     = rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < count) begin
        if (wb_addr_match(entries[idx].waddr, raddr0)) hazard0 = 1'b1;
        if (wb_addr_match(entries[idx].waddr, raddr1)) hazard1 = 1'b1;
      end
    end
  end

`ifdef WB_FWD_EN
  // ---------------------------------------------------------------------------
  // Forwarding: walk from head (oldest) to tail (youngest) with later matches
  // overriding earlier ones, after seeding with the output register; the
  // result is the youngest matching write.
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] fidx;

  always_comb begin
    fwd0_data = (we_q && wb_addr_match(waddr_q, raddr0)) ? din_q : '0;
    fwd1_data = (we_q && wb_addr_match(waddr_q, raddr1)) ? din_q : '0;
    fidx      = rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      fidx = rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < count) begin
        if (wb_addr_match(entries[fidx].waddr, raddr0)) fwd0_data = entries[fidx].data;
        if (wb_addr_match(entries[fidx].waddr, raddr1)) fwd1_data = entries[fidx].data;
      end
    end
  end

  assign fwd0_valid = hazard0;
  assign fwd1_valid = hazard1;
`else
  assign fwd0_valid = 1'b0;
  assign fwd0_data  = '0;
  assign fwd1_valid = 1'b0;
  assign fwd1_data  = '0;

  // Entry data is only consumed by forwarding; fold it into a sink so the
  // default build has no dangling bits.
  logic unused_entry_data;
  always_comb begin
    unused_entry_data = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      unused_entry_data = unused_entry_data ^ (^entries[i].data);
    end
  end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// -----------------------------------------------------------------------------
// tb_wb_queue
// Self-checking bench for wb_queue (DEPTH = 4). A queue-based reference model
// tracks pending writes and the output register; every cycle the DUT outputs
// are compared against it. Directed sections pin the model with literal
// expectations; a randomized section follows.
// -----------------------------------------------------------------------------
module tb_wb_queue;
  import wb_pkg::*;

  localparam int DEPTH = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic                 mem_valid, alu_valid;
  logic [WB_ADDR_W-1:0] mem_waddr, alu_waddr;
  logic [WB_DATA_W-1:0] mem_data, alu_data;
  logic                 mem_ready, alu_ready;
  logic                 we;
  logic [WB_ADDR_W-1:0] waddr;
  logic [WB_DATA_W-1:0] din;
  logic [RF_ADDR_W-1:0] raddr0, raddr1;
  logic                 hazard0, hazard1;
  logic                 fwd0_valid, fwd1_valid;
  logic [WB_DATA_W-1:0] fwd0_data, fwd1_data;

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_valid  (mem_valid),
    .mem_waddr  (mem_waddr),
    .mem_data   (mem_data),
    .alu_valid  (alu_valid),
    .alu_waddr  (alu_waddr),
    .alu_data   (alu_data),
    .mem_ready  (mem_ready),
    .alu_ready  (alu_ready),
    .we         (we),
    .waddr      (waddr),
    .din        (din),
    .raddr0     (raddr0),
    .raddr1     (raddr1),
    .hazard0    (hazard0),
    .hazard1    (hazard1),
    .fwd0_valid (fwd0_valid),
    .fwd0_data  (fwd0_data),
    .fwd1_valid (fwd1_valid),
    .fwd1_data  (fwd1_data)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: pending writes as {waddr, data}, oldest first.
  logic [37:0]          m_q[$];
  logic                 m_we;
  logic [WB_ADDR_W-1:0] m_waddr;
  logic [WB_DATA_W-1:0] m_din;

  // Writes the DUT actually performed, captured after every rising edge.
  logic [37:0] wr_log[$];
  // Writes a directed section requires, in order.
  logic [37:0] exp_q[$];

  always @(posedge clk) begin
    #1;
    if (we === 1'b1) wr_log.push_back({waddr, din});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_we    = 1'b0;
    m_waddr = '0;
    m_din   = '0;
  endtask

  function automatic logic model_hazard(input logic [RF_ADDR_W-1:0] r);
    logic hit;
    hit = m_we && (m_waddr == {1'b0, r});
    foreach (m_q[i]) if (m_q[i][37:32] == {1'b0, r}) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [31:0] model_fwd(input logic [RF_ADDR_W-1:0] r);
    // Youngest pending entry first, then the write in flight.
    for (int i = m_q.size() - 1; i >= 0; i--) begin
      if (m_q[i][37:32] == {1'b0, r}) return m_q[i][31:0];
    end
    if (m_we && (m_waddr == {1'b0, r})) return m_din;
    return 32'h0;
  endfunction

  // One rising edge of the specification's behaviour.
  task automatic model_step();
    int  free;
    bit  m_acc, a_acc;
    logic [37:0] e;
    free  = DEPTH - m_q.size();
    m_acc = mem_valid && (free >= 1);
    a_acc = alu_valid && (mem_valid ? (free >= 2) : (free >= 1));
    if (m_acc) m_q.push_back({mem_waddr, mem_data});
    if (a_acc) m_q.push_back({alu_waddr, alu_data});
    if (m_q.size() > 0) begin
      e       = m_q.pop_front();
      m_we    = 1'b1;
      m_waddr = e[37:32];
      m_din   = e[31:0];
    end else begin
      m_we = 1'b0;
    end
  endtask

  // Compare every DUT output with the model.
  task automatic compare_all();
    int free;
    free = DEPTH - m_q.size();
    check("mem_ready", mem_ready, (free >= 1));
    check("alu_ready", alu_ready, mem_valid ? (free >= 2) : (free >= 1));
    check("we", we, m_we);
    check("waddr", waddr, m_waddr);
    check("din", din, m_din);
    check("hazard0", hazard0, model_hazard(raddr0));
    check("hazard1", hazard1, model_hazard(raddr1));
`ifdef WB_FWD_EN
    check("fwd0_valid", fwd0_valid, model_hazard(raddr0));
    check("fwd1_valid", fwd1_valid, model_hazard(raddr1));
    check("fwd0_data", fwd0_data, model_fwd(raddr0));
    check("fwd1_data", fwd1_data, model_fwd(raddr1));
`else
    check("fwd0_valid", fwd0_valid, 1'b0);
    check("fwd1_valid", fwd1_valid, 1'b0);
    check("fwd0_data", fwd0_data, 32'h0);
    check("fwd1_data", fwd1_data, 32'h0);
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called at the falling edge)
  // ---------------------------------------------------------------------------
  task automatic drive(input logic mv, input logic [5:0] ma, input logic [31:0] md,
                       input logic av, input logic [5:0] aa, input logic [31:0] ad,
                       input logic [4:0] r0, input logic [4:0] r1);
    mem_valid = mv; mem_waddr = ma; mem_data = md;
    alu_valid = av; alu_waddr = aa; alu_data = ad;
    raddr0    = r0; raddr1    = r1;
  endtask

  task automatic drive_idle(input logic [4:0] r0, input logic [4:0] r1);
    drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, r0, r1);
  endtask

  // Check this cycle, advance one clock, land on the next falling edge.
  task automatic tick();
    #1;
    compare_all();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    drive_idle(5'd0, 5'd0);
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state
    #1;
    check("rst_we", we, 1'b0);
    check("rst_waddr", waddr, 6'd0);
    check("rst_din", din, 32'h0);
    check("rst_mem_ready", mem_ready, 1'b1);
    check("rst_alu_ready", alu_ready, 1'b1);
    check("rst_hazard0", hazard0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single ALU write: one-cycle latency, then idle
    drive(1'b0, 6'd0, 32'h0, 1'b1, 6'd5, 32'h0000_0011, 5'd5, 5'd0);
    tick();
    drive_idle(5'd5, 5'd0);
    #1;
    check("alu1_we", we, 1'b1);
    check("alu1_waddr", waddr, 6'd5);
    check("alu1_din", din, 32'h11);
    check("alu1_hazard0", hazard0, 1'b1);
    tick();
    #1;
    check("alu1_we_off", we, 1'b0);
    check("alu1_din_hold", din, 32'h11);
    check("alu1_hazard0_off", hazard0, 1'b0);
    tick();

    // mem and alu to the same register in one cycle: mem first, then alu
    drive(1'b1, 6'd3, 32'hAA, 1'b1, 6'd3, 32'hBB, 5'd3, 5'd4);
    tick();
    drive_idle(5'd3, 5'd4);
    #1;
    check("dual_we0", we, 1'b1);
    check("dual_waddr0", waddr, 6'd3);
    check("dual_din0", din, 32'hAA);
    check("dual_hazard0", hazard0, 1'b1);
    check("dual_hazard1", hazard1, 1'b0);
`ifdef WB_FWD_EN
    check("dual_fwd0_young", fwd0_data, 32'hBB);
`endif
    tick();
    #1;
    check("dual_we1", we, 1'b1);
    check("dual_din1", din, 32'hBB);
`ifdef WB_FWD_EN
    check("dual_fwd0_outreg", fwd0_data, 32'hBB);
`endif
    tick();
    #1;
    check("dual_we_off", we, 1'b0);
    tick();

    // Fill to three pending entries, then mem gets in but alu does not
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'(8 + 2 * i), 32'h100 + 32'(i), 1'b1, 6'(9 + 2 * i), 32'h200 + 32'(i), 5'd8, 5'd9);
      tick();
    end
    drive(1'b1, 6'd20, 32'h300, 1'b1, 6'd21, 32'h301, 5'd20, 5'd21);
    #1;
    check("full3_mem_ready", mem_ready, 1'b1);
    check("full3_alu_ready", alu_ready, 1'b0);
    tick();
    drive_idle(5'd21, 5'd20);
    repeat (6) tick();

    // Twelve writes with the queue kept non-empty so both pointers wrap
    wr_log.delete();
    exp_q.delete();
    drive(1'b1, 6'd1, 32'hC000, 1'b1, 6'd2, 32'hC001, 5'd1, 5'd2);
    exp_q.push_back({6'd1, 32'hC000});
    exp_q.push_back({6'd2, 32'hC001});
    tick();
    for (int i = 2; i < 12; i++) begin
      drive(1'b0, 6'd0, 32'h0, 1'b1, 6'(i % 8), 32'hC000 + 32'(i), 5'(i % 8), 5'd1);
      exp_q.push_back({6'(i % 8), 32'hC000 + 32'(i)});
      tick();
    end
    drive_idle(5'd0, 5'd0);
    repeat (4) tick();
    check("wrap_write_count", wr_log.size(), 12);
    for (int i = 0; i < 12; i++) begin
      check("wrap_write_order", (i < wr_log.size()) ? wr_log[i][31:0] : 32'hDEAD_DEAD, exp_q[i][31:0]);
    end

    // Reset pulse with three entries pending
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'd7, 32'h700 + 32'(i), 1'b1, 6'd6, 32'h600 + 32'(i), 5'd7, 5'd6);
      tick();
    end
    drive_idle(5'd7, 5'd6);
    #1;
    check("pre_rst_hazard0", hazard0, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    wr_log.delete();
    check("mid_rst_we", we, 1'b0);
    check("mid_rst_waddr", waddr, 6'd0);
    check("mid_rst_din", din, 32'h0);
    check("mid_rst_hazard0", hazard0, 1'b0);
    check("mid_rst_hazard1", hazard1, 1'b0);
    check("mid_rst_fwd0", fwd0_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    check("post_rst_no_writes", wr_log.size(), 0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)),
            6'($urandom_range(0, 7) + (($urandom_range(0, 5) == 0) ? 32 : 0)),
            32'($urandom),
            1'($urandom_range(0, 1)),
            6'($urandom_range(0, 7) + (($urandom_range(0, 5) == 0) ? 32 : 0)),
            32'($urandom),
            5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)));
      tick();
    end
    drive_idle(5'd0, 5'd0);
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
